// File: rtl/z3_master.sv
// z3_master: Zorro III bus-master engine. It turns single local DMA transfer
// requests into complete Zorro III master cycles. Each cycle runs arbitration,
// the address phase, the data phase, termination and bus release.
//
// Ports:
//   CLK, IORST_n            clock, async active-low reset
//   m_req/m_addr/m_read/    local request: address, direction, size
//   m_siz/m_wdata           (00 long, 01 byte, 10 word) and write data
//   m_ack/m_err             one-cycle completion / error pulses
//   m_rdata, m_busy         read data (held until the next m_ack), engine busy
//   BR_n, BG_n              bus request out, bus grant in (asynchronous)
//   FCS_in_n                bus FCS_n, sampled to detect an idle bus
//   DTACK_n, BERR_n         slave termination inputs (asynchronous)
//   D_in                    bus read data
//   A_out, A_oe             address and its driver enable
//   FCS_n, DS_n, READ_out   cycle strobe, byte-lane data strobes, direction
//   DOE, D_out, D_oe        data output enable, write data, data driver enable
//   MASTER                  card owns the bus (buffer direction steering)
module z3_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        IORST_n,
  input  logic        m_req,
  input  logic [31:0] m_addr,
  input  logic        m_read,
  input  logic [1:0]  m_siz,
  input  logic [31:0] m_wdata,
  output logic        m_ack,
  output logic        m_err,
  output logic [31:0] m_rdata,
  output logic        m_busy,
  output logic        BR_n,
  input  logic        BG_n,
  input  logic        FCS_in_n,
  input  logic        DTACK_n,
  input  logic        BERR_n,
  input  logic [31:0] D_in,
  output logic [31:0] A_out,
  output logic        A_oe,
  output logic        FCS_n,
  output logic [3:0]  DS_n,
  output logic        READ_out,
  output logic        DOE,
  output logic [31:0] D_out,
  output logic        D_oe,
  output logic        MASTER
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned SYN_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    OWN  = 3'd2,
    ADDR = 3'd3,
    DATA = 3'd4,
    TERM = 3'd5,
    REL  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_q, rd_d;
  logic [1:0]         siz_q, siz_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [SYN_W-1:0]   sync1_q, sync2_q;

  logic               m_ack_d, m_err_d, m_busy_d, br_n_d, a_oe_d, fcs_n_d;
  logic               read_out_d, doe_d, d_oe_d, master_d;
  logic [3:0]         ds_n_d;
  logic [31:0]        m_rdata_d, a_out_d, d_out_d;

  logic               bg_s, fcs_s, dtack_s, berr_s;
  logic               illegal_c;

  // Two-flop synchronizers for the asynchronous bus inputs, idle-high.
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {BG_n, FCS_in_n, DTACK_n, BERR_n};
      sync2_q <= sync1_q;
    end
  end

  assign {bg_s, fcs_s, dtack_s, berr_s} = sync2_q;

  // Sizes and alignments the bus cannot express in one transfer.
  assign illegal_c = (m_siz == 2'b11) ||
                     ((m_siz == 2'b00) && (m_addr[1:0] != 2'b00)) ||
                     ((m_siz == 2'b10) && m_addr[0]);

  // Byte-lane strobes; lane 3 carries D[31:24], the byte at offset 0.
  function automatic logic [3:0] lane_decode(input logic [1:0] siz,
                                             input logic [1:0] a);
    logic [3:0] ds;
    ds = 4'b1111;
    case (siz)
      2'b00:   ds = 4'b0000;
      2'b10:   ds = a[1] ? 4'b1100 : 4'b0011;
      2'b01:   ds[2'd3 - a] = 1'b0;
      default: ds = 4'b1111;
    endcase
    return ds;
  endfunction

  // Next-state and next-output logic; outputs hold unless a state changes them.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    siz_d      = siz_q;
    wdata_d    = wdata_q;
    m_ack_d    = 1'b0;
    m_err_d    = 1'b0;
    m_busy_d   = m_busy;
    m_rdata_d  = m_rdata;
    br_n_d     = BR_n;
    a_out_d    = A_out;
    a_oe_d     = A_oe;
    fcs_n_d    = FCS_n;
    ds_n_d     = DS_n;
    read_out_d = READ_out;
    doe_d      = DOE;
    d_out_d    = D_out;
    d_oe_d     = D_oe;
    master_d   = MASTER;

    case (state_q)
      IDLE: begin
        // Skip the cycle m_err is showing so a still-held request is not
        // rejected twice.
        if (m_req && !m_err) begin
          if (illegal_c) begin
            m_err_d = 1'b1;
          end else begin
            rd_d     = m_read;
            siz_d    = m_siz;
            wdata_d  = m_wdata;
            a_out_d  = m_addr;
            m_busy_d = 1'b1;
            br_n_d   = 1'b0;
            state_d  = ARB;
          end
        end
      end

      ARB: begin
        if (!bg_s && fcs_s && dtack_s) begin
          br_n_d     = 1'b1;
          master_d   = 1'b1;
          a_oe_d     = 1'b1;
          read_out_d = rd_q;
          state_d    = OWN;
        end
      end

      OWN: begin
        fcs_n_d = 1'b0;
        if (!rd_q) begin
          d_oe_d  = 1'b1;
          d_out_d = wdata_q;
        end
        state_d = ADDR;
      end

      ADDR: begin
        doe_d   = 1'b1;
        ds_n_d  = lane_decode(siz_q, A_out[1:0]);
        cnt_d   = '0;
        state_d = DATA;
      end

      DATA: begin
        if (!berr_s) begin
          m_err_d = 1'b1;
        end else if (!dtack_s) begin
          m_ack_d = 1'b1;
          if (rd_q) begin
            m_rdata_d = D_in;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          m_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (m_ack_d || m_err_d) begin
          fcs_n_d = 1'b1;
          ds_n_d  = 4'b1111;
          doe_d   = 1'b0;
          d_oe_d  = 1'b0;
          state_d = TERM;
        end
      end

      TERM: begin
        if (dtack_s && berr_s) begin
          state_d = REL;
        end
      end

      REL: begin
        a_oe_d     = 1'b0;
        master_d   = 1'b0;
        m_busy_d   = 1'b0;
        read_out_d = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= 1'b1;
      siz_q    <= 2'b00;
      wdata_q  <= '0;
      m_ack    <= 1'b0;
      m_err    <= 1'b0;
      m_busy   <= 1'b0;
      m_rdata  <= '0;
      BR_n     <= 1'b1;
      A_out    <= '0;
      A_oe     <= 1'b0;
      FCS_n    <= 1'b1;
      DS_n     <= 4'b1111;
      READ_out <= 1'b1;
      DOE      <= 1'b0;
      D_out    <= '0;
      D_oe     <= 1'b0;
      MASTER   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      siz_q    <= siz_d;
      wdata_q  <= wdata_d;
      m_ack    <= m_ack_d;
      m_err    <= m_err_d;
      m_busy   <= m_busy_d;
      m_rdata  <= m_rdata_d;
      BR_n     <= br_n_d;
      A_out    <= a_out_d;
      A_oe     <= a_oe_d;
      FCS_n    <= fcs_n_d;
      DS_n     <= ds_n_d;
      READ_out <= read_out_d;
      DOE      <= doe_d;
      D_out    <= d_out_d;
      D_oe     <= d_oe_d;
      MASTER   <= master_d;
    end
  end

endmodule

// File: tb/tb_z3_master.sv
// Directed bench for z3_master; a short timeout keeps the timeout case brief.
module tb_z3_master;

  localparam int unsigned TO = 15;

  logic        CLK = 1'b0;
  logic        IORST_n;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_read;
  logic [1:0]  m_siz;
  logic [31:0] m_wdata;
  logic        m_ack, m_err, m_busy;
  logic [31:0] m_rdata;
  logic        BR_n, BG_n, FCS_in_n, DTACK_n, BERR_n;
  logic [31:0] D_in, A_out, D_out;
  logic        A_oe, FCS_n, READ_out, DOE, D_oe, MASTER;
  logic [3:0]  DS_n;

  int checks = 0;
  int errors = 0;

  z3_master #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .IORST_n(IORST_n),
    .m_req(m_req), .m_addr(m_addr), .m_read(m_read), .m_siz(m_siz),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .m_busy(m_busy), .BR_n(BR_n), .BG_n(BG_n), .FCS_in_n(FCS_in_n),
    .DTACK_n(DTACK_n), .BERR_n(BERR_n), .D_in(D_in), .A_out(A_out),
    .A_oe(A_oe), .FCS_n(FCS_n), .DS_n(DS_n), .READ_out(READ_out),
    .DOE(DOE), .D_out(D_out), .D_oe(D_oe), .MASTER(MASTER)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " BR_n"},     32'(BR_n), 32'd1);
    chk({tag, " FCS_n"},    32'(FCS_n), 32'd1);
    chk({tag, " DS_n"},     32'(DS_n), 32'hF);
    chk({tag, " READ_out"}, 32'(READ_out), 32'd1);
    chk({tag, " DOE"},      32'(DOE), 32'd0);
    chk({tag, " A_oe"},     32'(A_oe), 32'd0);
    chk({tag, " D_oe"},     32'(D_oe), 32'd0);
    chk({tag, " MASTER"},   32'(MASTER), 32'd0);
    chk({tag, " m_ack"},    32'(m_ack), 32'd0);
    chk({tag, " m_err"},    32'(m_err), 32'd0);
    chk({tag, " m_busy"},   32'(m_busy), 32'd0);
    chk({tag, " A_out"},    A_out, 32'd0);
    chk({tag, " D_out"},    D_out, 32'd0);
    chk({tag, " m_rdata"},  m_rdata, 32'd0);
  endtask

  task automatic request(input logic [31:0] a, input logic rd,
                         input logic [1:0] s, input logic [31:0] wd);
    m_req = 1'b1; m_addr = a; m_read = rd; m_siz = s; m_wdata = wd;
  endtask

  initial begin
    IORST_n = 1'b0; m_req = 1'b0; m_addr = '0; m_read = 1'b0; m_siz = 2'b00;
    m_wdata = '0; BG_n = 1'b1; FCS_in_n = 1'b1; DTACK_n = 1'b1; BERR_n = 1'b1;
    D_in = '0;

    // Reset values while reset is held.
    ticks(2);
    chk_reset_vals("rst");
    IORST_n = 1'b1;

    // Long read, grant already present; DTACK 3 cycles after DS_n.
    BG_n = 1'b0;
    ticks(3);
    request(32'h4000_0000, 1'b1, 2'b00, 32'h0);
    tick(); // edge 0
    chk("rd BR_n e0", 32'(BR_n), 32'd0);
    chk("rd busy e0", 32'(m_busy), 32'd1);
    chk("rd MASTER e0", 32'(MASTER), 32'd0);
    tick(); // edge 1
    chk("rd MASTER e1", 32'(MASTER), 32'd1);
    chk("rd A_oe e1", 32'(A_oe), 32'd1);
    chk("rd BR_n e1", 32'(BR_n), 32'd1);
    chk("rd A_out e1", A_out, 32'h4000_0000);
    chk("rd FCS_n e1", 32'(FCS_n), 32'd1);
    tick(); // edge 2
    chk("rd FCS_n e2", 32'(FCS_n), 32'd0);
    chk("rd DS_n e2", 32'(DS_n), 32'hF);
    tick(); // edge 3
    chk("rd DS_n e3", 32'(DS_n), 32'h0);
    chk("rd DOE e3", 32'(DOE), 32'd1);
    chk("rd D_oe e3", 32'(D_oe), 32'd0);
    ticks(3); // edge 6
    DTACK_n = 1'b0; D_in = 32'hDEAD_BEEF;
    ticks(2); // edge 8
    chk("rd ack early", 32'(m_ack), 32'd0);
    tick(); // edge 9
    chk("rd ack", 32'(m_ack), 32'd1);
    chk("rd err", 32'(m_err), 32'd0);
    chk("rd rdata", m_rdata, 32'hDEAD_BEEF);
    chk("rd FCS_n term", 32'(FCS_n), 32'd1);
    chk("rd DS_n term", 32'(DS_n), 32'hF);
    chk("rd DOE term", 32'(DOE), 32'd0);
    m_req = 1'b0;
    tick(); // edge 10
    chk("rd ack pulse", 32'(m_ack), 32'd0);
    tick(); // edge 11
    DTACK_n = 1'b1;
    ticks(3); // edge 14: REL
    chk("rd MASTER rel", 32'(MASTER), 32'd1);
    chk("rd A_out rel", A_out, 32'h4000_0000);
    tick(); // edge 15: IDLE
    chk("rd MASTER idle", 32'(MASTER), 32'd0);
    chk("rd busy idle", 32'(m_busy), 32'd0);
    chk("rd A_oe idle", 32'(A_oe), 32'd0);

    // Byte write of 0x5A at offset 2 with a late grant.
    BG_n = 1'b1;
    ticks(3);
    request(32'h1234_5602, 1'b0, 2'b01, 32'h0000_5A00);
    tick(); // edge 0
    chk("wr BR_n e0", 32'(BR_n), 32'd0);
    ticks(10); // edge 10
    chk("wr BR_n wait", 32'(BR_n), 32'd0);
    chk("wr MASTER wait", 32'(MASTER), 32'd0);
    BG_n = 1'b0;
    ticks(2); // edge 12
    chk("wr BR_n sync", 32'(BR_n), 32'd0);
    tick(); // edge 13
    chk("wr MASTER own", 32'(MASTER), 32'd1);
    chk("wr BR_n own", 32'(BR_n), 32'd1);
    chk("wr READ_out", 32'(READ_out), 32'd0);
    tick(); // edge 14
    chk("wr FCS_n", 32'(FCS_n), 32'd0);
    chk("wr D_oe", 32'(D_oe), 32'd1);
    chk("wr D_out", D_out, 32'h0000_5A00);
    tick(); // edge 15
    chk("wr DS_n", 32'(DS_n), 32'hD);
    chk("wr DOE", 32'(DOE), 32'd1);
    DTACK_n = 1'b0;
    ticks(2); // edge 17
    chk("wr ack early", 32'(m_ack), 32'd0);
    tick(); // edge 18
    chk("wr ack", 32'(m_ack), 32'd1);
    chk("wr D_oe term", 32'(D_oe), 32'd0);
    chk("wr rdata kept", m_rdata, 32'hDEAD_BEEF);
    m_req = 1'b0; DTACK_n = 1'b1;
    ticks(3); // edge 21: REL
    chk("wr MASTER rel", 32'(MASTER), 32'd1);
    tick(); // edge 22
    chk("wr MASTER idle", 32'(MASTER), 32'd0);
    chk("wr busy idle", 32'(m_busy), 32'd0);

    // Misaligned word read is rejected without touching the bus.
    request(32'h0000_0101, 1'b1, 2'b10, 32'h0);
    tick();
    chk("ill err", 32'(m_err), 32'd1);
    chk("ill BR_n", 32'(BR_n), 32'd1);
    chk("ill busy", 32'(m_busy), 32'd0);
    m_req = 1'b0;
    tick();
    chk("ill err pulse", 32'(m_err), 32'd0);
    ticks(2);
    chk("ill BR_n later", 32'(BR_n), 32'd1);
    chk("ill FCS_n", 32'(FCS_n), 32'd1);
    chk("ill MASTER", 32'(MASTER), 32'd0);

    // BERR_n and DTACK_n together: error wins.
    request(32'h0000_1000, 1'b1, 2'b00, 32'h0);
    ticks(4); // edge 3
    DTACK_n = 1'b0; BERR_n = 1'b0; D_in = 32'h0BAD_0BAD;
    ticks(2); // edge 5
    chk("be err early", 32'(m_err), 32'd0);
    tick(); // edge 6
    chk("be err", 32'(m_err), 32'd1);
    chk("be ack", 32'(m_ack), 32'd0);
    chk("be FCS_n", 32'(FCS_n), 32'd1);
    chk("be DS_n", 32'(DS_n), 32'hF);
    chk("be rdata kept", m_rdata, 32'hDEAD_BEEF);
    m_req = 1'b0;
    tick(); // edge 7
    chk("be err pulse", 32'(m_err), 32'd0);
    DTACK_n = 1'b1;
    ticks(2); // edge 9
    BERR_n = 1'b1;
    ticks(3); // edge 12: REL
    chk("be MASTER rel", 32'(MASTER), 32'd1);
    tick(); // edge 13
    chk("be MASTER idle", 32'(MASTER), 32'd0);

    // No termination: timeout after TO+1 DATA cycles.
    request(32'h0000_2000, 1'b1, 2'b00, 32'h0);
    ticks(4); // edge 3, DATA entered
    ticks(TO); // edge 18
    chk("to err early", 32'(m_err), 32'd0);
    chk("to FCS_n early", 32'(FCS_n), 32'd0);
    tick(); // edge 19
    chk("to err", 32'(m_err), 32'd1);
    chk("to FCS_n", 32'(FCS_n), 32'd1);
    chk("to DS_n", 32'(DS_n), 32'hF);
    chk("to DOE", 32'(DOE), 32'd0);
    m_req = 1'b0;
    tick(); // edge 20: REL
    chk("to MASTER rel", 32'(MASTER), 32'd1);
    tick(); // edge 21
    chk("to MASTER idle", 32'(MASTER), 32'd0);
    chk("to busy idle", 32'(m_busy), 32'd0);

    // Reset in the middle of a write data phase.
    request(32'h0000_3004, 1'b0, 2'b00, 32'h1122_3344);
    ticks(5); // edge 4, in DATA
    chk("mr D_oe pre", 32'(D_oe), 32'd1);
    IORST_n = 1'b0;
    m_req = 1'b0;
    #1;
    chk_reset_vals("mr");
    tick();
    chk("mr MASTER held", 32'(MASTER), 32'd0);
    IORST_n = 1'b1;
    ticks(3);
    request(32'h0000_4008, 1'b1, 2'b00, 32'h0);
    tick(); // edge 0
    chk("pr BR_n", 32'(BR_n), 32'd0);
    ticks(3); // edge 3
    chk("pr DS_n", 32'(DS_n), 32'h0);
    DTACK_n = 1'b0; D_in = 32'hCAFE_F00D;
    ticks(3); // edge 6
    chk("pr ack", 32'(m_ack), 32'd1);
    chk("pr rdata", m_rdata, 32'hCAFE_F00D);
    m_req = 1'b0; DTACK_n = 1'b1;
    ticks(4); // edge 10
    chk("pr MASTER idle", 32'(MASTER), 32'd0);
    chk("pr busy idle", 32'(m_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/z3_master.md
# z3_master

Zorro III bus-master engine for the A4092. It turns single-transfer requests from the local DMA side (the SCSI controller's DMA path) into complete Zorro III master cycles. Each cycle runs bus request and grant, address phase with FCS_n, data phase with DS_n/DOE, DTACK_n/BERR_n termination, and bus release. It is the initiator counterpart of the card's Zorro III slave decode, and shares CLK and IORST_n with it.

## Interface
- TIMEOUT, 255: CLK cycles allowed in the data phase before the cycle is aborted with an error.
- CLK  in  1  system clock; all state changes occur on its rising edge.
- IORST_n  in  1  asynchronous, active-low reset.
- m_req  in  1  local request. Sampled only in IDLE. Must be held until m_ack or m_err.
- m_addr  in  32  transfer address.
- m_read  in  1  1 = read, 0 = write.
- m_siz  in  2  transfer size: 00 long, 01 byte, 10 word; 11 is illegal.
- m_wdata  in  32  write data, big-endian lanes, D[31:24] = byte at offset 0.
- m_ack  out  1  one-cycle pulse on successful completion.
- m_err  out  1  one-cycle pulse on bus error, timeout or illegal request.
- m_rdata  out  32  read data, valid from the m_ack cycle until the next m_ack.
- m_busy  out  1  high from request acceptance until return to IDLE.
- BR_n  out  1  bus request.
- BG_n  in  1  bus grant; asynchronous, 2-flop synchronized.
- FCS_in_n  in  1  bus FCS_n, used for idle detection; 2-flop synchronized.
- DTACK_n  in  1  2-flop synchronized.
- BERR_n  in  1  2-flop synchronized.
- D_in  in  32  bus data.
- A_out  out  32  address, registered at acceptance.
- A_oe  out  1  address driver enable.
- FCS_n  out  1  full cycle strobe.
- DS_n  out  4  data strobes; DS_n[3] = D[31:24].
- READ_out  out  1  bus READ.
- DOE  out  1  data output enable.
- D_out  out  32  write data.
- D_oe  out  1  data driver enable, writes only.
- MASTER  out  1  card owns the bus; steers the buffer direction logic.

## Operation
- States: IDLE, ARB, OWN, ADDR, DATA, TERM, REL.
- IDLE: when m_req=1, latch the address, read, size and wdata, then check the request.
  - Illegal if m_siz=11, or long with m_addr[1:0]≠00, or word with m_addr[0]=1.
  - Illegal request: pulse m_err next cycle, stay in IDLE, no bus activity.
  - Legal request: set m_busy=1, BR_n=0, go to ARB.
- ARB: wait until synchronized BG_n=0, FCS_in_n=1 and DTACK_n=1 are all true on the same edge. Then go to OWN and set BR_n=1, MASTER=1, A_oe=1, READ_out=m_read.
- OWN: go to ADDR and set FCS_n=0. On a write, also set D_oe=1 and D_out=m_wdata.
- ADDR: go to DATA, set DOE=1 and drive DS_n from the byte lanes:
  - long: DS_n=0000.
  - word: addr[1]=0 gives 0011; addr[1]=1 gives 1100.
  - byte: lane 3-addr[1:0] low, others high.
  - Reads use the same decode.
- DATA: clear the timeout counter on entry. Evaluate in this priority order:
  - synchronized BERR_n=0: error. It wins if DTACK_n=0 on the same edge.
  - synchronized DTACK_n=0: success. m_rdata<=D_in on that edge (reads only).
  - counter reaches TIMEOUT: error.
  - otherwise increment the counter.
  - On success or error: go to TERM, set FCS_n=1, DS_n=1111, DOE=0, D_oe=0, and pulse m_ack or m_err.
- TERM: hold until synchronized DTACK_n=1 and BERR_n=1, then go to REL. This state has no timeout.
- REL: set A_oe=0, MASTER=0, m_busy=0, go to IDLE. The next request is sampled in the following cycle; there is no bus parking.
- Reset, including mid-cycle: all state and outputs go to their reset values immediately. The bus is released within the reset itself.

## Timing
- Reset values:
  - BR_n=1, FCS_n=1, DS_n=1111, READ_out=1.
  - DOE=0, A_oe=0, D_oe=0, MASTER=0.
  - m_ack=0, m_err=0, m_busy=0.
  - A_out=0, D_out=0, m_rdata=0.
  - All synchronizers reset to 1.
- All outputs are registered.
- Grant already asserted and bus idle, with m_req sampled at edge 0:
  - BR_n low after edge 0.
  - MASTER and A_oe after edge 1.
  - FCS_n low after edge 2.
  - DS_n and DOE after edge 3.
- DTACK_n falling before edge k: synchronized at k+1, so TERM and m_ack follow edge k+2.
- Address is stable from OWN through REL. Write data is stable from OWN until D_oe drops. FCS_n precedes DS_n by one cycle.
- m_ack and m_err are mutually exclusive and last exactly one cycle.
- Timeout: m_err follows the edge where the counter equals TIMEOUT, i.e. TIMEOUT+1 DATA cycles after entry.

## Test plan
- Long read at 0x4000_0000, BG_n held low, slave drives D=0xDEADBEEF and DTACK_n low 3 cycles after DS_n.
  - BR_n low 1 cycle after m_req, FCS_n low 2 cycles later, DS_n=0000.
  - m_ack with m_rdata=0xDEADBEEF.
  - Return to IDLE after DTACK_n negates.
- Byte write 0x5A at addr 0x...02, BG_n delayed 10 cycles.
  - BR_n held low until the grant is seen.
  - DS_n=1101, D_oe=1, D_out=m_wdata.
  - m_ack; MASTER low in REL.
- Word read at addr 0x...01 → m_err the next cycle; BR_n, FCS_n and MASTER never asserted.
- BERR_n and DTACK_n asserted on the same cycle → m_err (not m_ack), FCS_n negated, bus released after both negate.
- No DTACK_n, TIMEOUT=15 → m_err 16 cycles after DATA entry, strobes negated, MASTER released.
- IORST_n pulsed low during DATA → all outputs at reset values during reset; the next m_req completes normally.
